// File: rtl/fetch_pc_unit.sv
// PC and instruction-fetch front end: owns the PC, drives a 1-cycle-latency
// instruction RAM, and registers returned words into the IR with a 1-entry skid.
module fetch_pc_unit #(
  parameter int          IMEM_AW      = 8,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         sel_pc,
  input  logic               load_pc,
  input  logic               stall_pc,
  input  logic [31:0]        branch_target,
  input  logic [31:0]        reg_target,
  input  logic [31:0]        imem_rdata,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_rd_en,
  output logic [31:0]        pc_out,
  output logic [31:0]        instr_out,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  output logic               align_fault,
  output logic [31:0]        fetch_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [31:0] pc_reg;
  logic        req_valid_reg;
  logic [31:0] req_pc_reg;
  logic        skid_valid_reg;
  logic [31:0] skid_data_reg;
  logic [31:0] skid_pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] ir_pc_reg;
  logic        ir_valid_reg;
  logic        align_fault_reg;
  logic [31:0] fetch_count_reg;

  logic [31:0] redirect_target;
  logic        issue;
  logic        ir_load;
  logic [31:0] ir_data_next;
  logic [31:0] ir_pc_next;

  // Control FSM: the first redirect starts fetching; only reset returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load_pc) begin
          state_next = RUN;
        end
      end
      RUN: begin
        issue = !load_pc && !stall_pc;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    case (sel_pc)
      2'b00:   redirect_target = pc_reg + 32'd4;
      2'b01:   redirect_target = RESET_VECTOR;
      2'b10:   redirect_target = branch_target;
      default: redirect_target = reg_target;
    endcase
  end

  // A live RAM response takes precedence over the skid; both can never be
  // pending at once because a stall always leaves req_valid cleared.
  always_comb begin
    ir_load      = 1'b0;
    ir_data_next = imem_rdata;
    ir_pc_next   = req_pc_reg;
    if (state_reg == RUN && !load_pc && !stall_pc) begin
      if (req_valid_reg) begin
        ir_load = 1'b1;
      end else if (skid_valid_reg) begin
        ir_load      = 1'b1;
        ir_data_next = skid_data_reg;
        ir_pc_next   = skid_pc_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_VECTOR;
      req_valid_reg   <= 1'b0;
      req_pc_reg      <= 32'd0;
      skid_valid_reg  <= 1'b0;
      skid_data_reg   <= 32'd0;
      skid_pc_reg     <= 32'd0;
      ir_reg          <= 32'd0;
      ir_pc_reg       <= 32'd0;
      ir_valid_reg    <= 1'b0;
      align_fault_reg <= 1'b0;
      fetch_count_reg <= 32'd0;
    end else begin
      align_fault_reg <= load_pc && (redirect_target[1:0] != 2'b00);
      req_valid_reg   <= issue;
      if (issue) begin
        req_pc_reg <= pc_reg;
      end
      if (load_pc) begin
        // Redirect squashes whatever is in flight or parked in the skid.
        pc_reg         <= {redirect_target[31:2], 2'b00};
        skid_valid_reg <= 1'b0;
        ir_valid_reg   <= 1'b0;
      end else if (state_reg == RUN) begin
        if (stall_pc) begin
          if (req_valid_reg) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= imem_rdata;
            skid_pc_reg    <= req_pc_reg;
          end
        end else begin
          pc_reg <= pc_reg + 32'd4;
          if (ir_load) begin
            ir_reg          <= ir_data_next;
            ir_pc_reg       <= ir_pc_next;
            ir_valid_reg    <= 1'b1;
            fetch_count_reg <= fetch_count_reg + 32'd1;
            skid_valid_reg  <= 1'b0;
          end else begin
            ir_valid_reg <= 1'b0;
          end
        end
      end
    end
  end

  assign imem_rd_en  = issue;
  assign imem_addr   = pc_reg[IMEM_AW+1:2];
  assign pc_out      = pc_reg;
  assign instr_out   = ir_reg;
  assign instr_pc    = ir_pc_reg;
  assign instr_valid = ir_valid_reg;
  assign align_fault = align_fault_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios with literal pins, then random
// redirect/stall traffic checked every cycle against a queue-based fetch model.
`timescale 1ns/1ps
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel_pc;
  logic        load_pc;
  logic        stall_pc;
  logic [31:0] branch_target;
  logic [31:0] reg_target;
  logic [31:0] imem_rdata;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        align_fault;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;

  fetch_pc_unit #(.IMEM_AW(8), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .sel_pc(sel_pc), .load_pc(load_pc),
    .stall_pc(stall_pc), .branch_target(branch_target), .reg_target(reg_target),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .pc_out(pc_out), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .align_fault(align_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction RAM, word i holds E000_0000 + i.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hE000_0000 + i;
  end
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  // Reference model: a queue of fetched-but-undelivered PCs; the oldest one
  // enters the IR on any unstalled running cycle, and a redirect empties it.
  logic        m_run   = 1'b0;
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_ir    = 32'd0;
  logic [31:0] m_ipc   = 32'd0;
  logic        m_iv    = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_cnt   = 32'd0;
  logic [31:0] q [$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hE000_0000 + {24'd0, a[9:2]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] tgt;
    logic [31:0] a;
    if (!rst_n) begin
      m_run = 1'b0; m_pc = 32'd0; m_ir = 32'd0; m_ipc = 32'd0;
      m_iv = 1'b0; m_fault = 1'b0; m_cnt = 32'd0; q.delete();
    end else begin
      m_fault = 1'b0;
      if (load_pc) begin
        case (sel_pc)
          2'd0:    tgt = m_pc + 32'd4;
          2'd1:    tgt = 32'd0;
          2'd2:    tgt = branch_target;
          default: tgt = reg_target;
        endcase
        $display("redirect sel=%0d target=%h", sel_pc, tgt);
        m_fault = (tgt % 4) != 0;
        m_pc    = tgt - (tgt % 4);
        q.delete();
        m_iv    = 1'b0;
        m_run   = 1'b1;
      end else if (m_run && !stall_pc) begin
        if (q.size() > 0) begin
          a     = q.pop_front();
          m_ir  = word_at(a);
          m_ipc = a;
          m_iv  = 1'b1;
          m_cnt = m_cnt + 1;
        end else begin
          m_iv = 1'b0;
        end
        q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("pc_out", pc_out, m_pc);
    chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc[9:2]});
    chk("imem_rd_en", {31'd0, imem_rd_en}, {31'd0, m_run && !load_pc && !stall_pc});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
    chk("instr_out", instr_out, m_ir);
    chk("instr_pc", instr_pc, m_ipc);
    chk("align_fault", {31'd0, align_fault}, {31'd0, m_fault});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  // Inputs are set at a negedge; compare 1ns later, then wait for next negedge.
  task automatic tick();
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic redirect(input logic [1:0] s, input logic [31:0] bt, input logic [31:0] rt);
    load_pc = 1'b1; sel_pc = s; branch_target = bt; reg_target = rt;
    tick();
    load_pc = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      stall_pc      = ($urandom_range(0, 99) < 30);
      load_pc       = ($urandom_range(0, 99) < 6);
      sel_pc        = 2'($urandom_range(0, 3));
      branch_target = $urandom;
      reg_target    = $urandom;
      tick();
    end
    load_pc = 1'b0;
    stall_pc = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_pc = 1'b0; stall_pc = 1'b0; sel_pc = 2'b00;
    branch_target = 32'd0; reg_target = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset pc_out", pc_out, 32'd0);
    chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset fetch_count", fetch_count, 32'd0);
    chk("reset imem_rd_en", {31'd0, imem_rd_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle no fetch", {31'd0, imem_rd_en}, 32'd0);

    // Start from the reset vector and stream words 0..2.
    redirect(2'b01, 32'd0, 32'd0);
    #1 chk("first addr", {24'd0, imem_addr}, 32'd0);
    chk("first rd_en", {31'd0, imem_rd_en}, 32'd1);
    tick(); tick();
    chk("w0 instr", instr_out, 32'hE000_0000);
    chk("w0 pc", instr_pc, 32'd0);
    tick();
    chk("w1 instr", instr_out, 32'hE000_0001);
    chk("w1 pc", instr_pc, 32'd4);
    tick();

    // Stall as word 3 returns; it must park in the skid and drain later.
    stall_pc = 1'b1;
    #1 chk("stall rd_en", {31'd0, imem_rd_en}, 32'd0);
    tick(); tick(); tick();
    chk("stall hold", instr_out, 32'hE000_0002);
    chk("stall count", fetch_count, 32'd3);
    stall_pc = 1'b0;
    tick();
    chk("skid drain", instr_out, 32'hE000_0003);
    chk("skid pc", instr_pc, 32'h0000_000C);
    chk("count 4", fetch_count, 32'd4);
    tick();
    chk("after drain", instr_out, 32'hE000_0004);

    // Branch while word 5 is in flight.
    redirect(2'b10, 32'h40, 32'd0);
    chk("branch bubble", {31'd0, instr_valid}, 32'd0);
    chk("branch pc", pc_out, 32'h40);
    tick(); tick();
    chk("branch word", instr_out, 32'hE000_0010);
    chk("branch ipc", instr_pc, 32'h40);

    // Misaligned register target.
    redirect(2'b11, 32'd0, 32'h22);
    chk("fault pulse", {31'd0, align_fault}, 32'd1);
    chk("fault pc", pc_out, 32'h20);
    tick();
    chk("fault clears", {31'd0, align_fault}, 32'd0);
    tick();
    chk("word 8", instr_out, 32'hE000_0008);

    // PC wrap at the top of the address space.
    redirect(2'b11, 32'd0, 32'hFFFF_FFFC);
    chk("wrap no fault", {31'd0, align_fault}, 32'd0);
    tick();
    chk("wrap pc", pc_out, 32'd0);
    tick();
    chk("wrap word", instr_out, 32'hE000_00FF);
    chk("wrap ipc", instr_pc, 32'hFFFF_FFFC);

    // Redirect while stalled with the skid full.
    stall_pc = 1'b1;
    tick(); tick();
    redirect(2'b10, 32'h80, 32'd0);
    chk("stall redirect flush", {31'd0, instr_valid}, 32'd0);
    stall_pc = 1'b0;
    tick(); tick();
    chk("stall redirect word", instr_out, 32'hE000_0020);
    chk("stall redirect ipc", instr_pc, 32'h80);

    random_phase(1500);

    // Asynchronous reset mid-stream with the skid occupied.
    redirect(2'b01, 32'd0, 32'd0);
    tick(); tick();
    stall_pc = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async pc", pc_out, 32'd0);
    chk("async instr", instr_out, 32'd0);
    chk("async ipc", instr_pc, 32'd0);
    chk("async valid", {31'd0, instr_valid}, 32'd0);
    chk("async count", fetch_count, 32'd0);
    chk("async rd_en", {31'd0, imem_rd_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_pc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post reset idle", {31'd0, imem_rd_en}, 32'd0);
    end

    random_phase(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
